// File: rtl/i2c_target.sv
// I2C target that maps bus transfers onto a byte-wide register port (pointer, write, read).
// Optional define I2C_TARGET_FILTER_EN adds a 3-sample majority filter on the synced SCL/SDA.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         PTR_W    = 8,
  parameter int         HOLD_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I2C_SCL,
  inout  wire              I2C_SDA,
  output logic [PTR_W-1:0] REG_ADDR,
  output logic [7:0]       REG_WDATA,
  output logic             REG_WE,
  output logic             REG_RE,
  input  logic [7:0]       REG_RDATA,
  output logic             BUSY
);

  localparam int HW = $clog2(HOLD_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_PTR, S_PACK, S_WDAT, S_WACK, S_RDAT, S_RACK, S_WAITP
  } state_t;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, cnt_n;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic [6:0]    shreg;
  logic [7:0]    tx;
  logic [7:0]    rx_byte;
  logic          rw, sda_oe, oe_tick;
  logic [HW-1:0] hold_cnt;
  logic          scl_rise, scl_fall, start, stop;
  logic          match, set_ptr, wr_stb, rd_stb, rd_inc;

  assign I2C_SDA = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], I2C_SCL};
      sda_sync <= {sda_sync[0], I2C_SDA};
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [1:0] scl_h, sda_h;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // A single-cycle pulse never wins the vote; the registered vote adds two cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_h <= 2'b11;
      sda_h <= 2'b11;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sync[1]};
      sda_h <= {sda_h[0], sda_sync[1]};
      scl_f <= maj3(scl_sync[1], scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_sync[1], sda_h[0], sda_h[1]);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // START/STOP qualify on the previous SCL level, so a same-cycle SCL fall still counts.
  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start    = scl_q & sda_q & ~sda_f;
  assign stop     = scl_q & ~sda_q & sda_f;
  assign rx_byte  = {shreg, sda_f};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      bit_cnt <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_n;
      bit_cnt <= cnt_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    cnt_n   = bit_cnt;
    match   = 1'b0;
    set_ptr = 1'b0;
    wr_stb  = 1'b0;
    rd_stb  = 1'b0;
    rd_inc  = 1'b0;
    oe_tick = 1'b0;
    case (state)
      S_AACK, S_PACK, S_WACK: oe_tick = 1'b1;
      S_RDAT:                 oe_tick = ~tx[7];
      default:                oe_tick = 1'b0;
    endcase
    if (start) begin
      state_n = S_ADDR;
      cnt_n   = 3'd0;
    end else if (stop) begin
      state_n = S_IDLE;
      cnt_n   = 3'd0;
    end else if (scl_rise) begin
      case (state)
        S_ADDR, S_PTR, S_WDAT, S_RDAT: begin
          cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              S_ADDR: begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_n = S_AACK;
                  match   = 1'b1;
                  rd_stb  = rx_byte[0];
                end else begin
                  state_n = S_IDLE;
                end
              end
              S_PTR: begin
                state_n = S_PACK;
                set_ptr = 1'b1;
              end
              S_WDAT: begin
                state_n = S_WACK;
                wr_stb  = 1'b1;
              end
              default: state_n = S_RACK;
            endcase
          end
        end
        S_AACK:         state_n = rw ? S_RDAT : S_PTR;
        S_PACK, S_WACK: state_n = S_WDAT;
        S_RACK: begin
          if (!sda_f) begin
            state_n = S_RDAT;
            rd_inc  = 1'b1;
            rd_stb  = 1'b1;
          end else begin
            state_n = S_WAITP;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      shreg     <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      hold_cnt  <= '0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WE    <= 1'b0;
      REG_RE    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      scl_q  <= scl_f;
      sda_q  <= sda_f;
      REG_WE <= wr_stb;
      REG_RE <= rd_stb;
      if (scl_rise) shreg <= rx_byte[6:0];
      if (match) rw <= rx_byte[0];
      if (wr_stb) REG_WDATA <= rx_byte;

      // The pointer moves only after the write strobe so REG_ADDR is stable while REG_WE is high.
      if (set_ptr) REG_ADDR <= PTR_W'(rx_byte);
      else if (REG_WE || rd_inc) REG_ADDR <= REG_ADDR + 1'b1;

      if (REG_RE) tx <= REG_RDATA;
      else if (scl_rise && state == S_RDAT) tx <= {tx[6:0], 1'b0};

      if (start || stop) BUSY <= 1'b0;
      else if (match) BUSY <= 1'b1;

      if (start || stop) begin
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_fall) begin
        hold_cnt <= HW'(HOLD_CYC);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) sda_oe <= oe_tick;
      end
    end
  end

endmodule
